// File: rtl/hack_fetch_unit.sv
// hack_fetch_unit: instruction fetch/issue stage of the Hack CPU.
// Owns the PC, fetches 16-bit words from instruction ROM over a req/ack
// handshake and hands them to decode over a valid/ready handshake. Jump
// redirects from execute retarget the PC and discard any in-flight or
// buffered instruction.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   rom_req/rom_addr               ROM read request and address (held until ack)
//   rom_ack/rom_data               ROM one-cycle data-valid pulse and data
//   instr_out/instr_pc/instr_valid instruction to decode, its address, valid
//   instr_ready                    decode accepts instr_out this cycle
//   jump_taken/jump_target         one-cycle redirect pulse and target
//   icount                         accepted-instruction counter (FETCH_ICOUNT_EN only)
//
// Optional feature macro: FETCH_ICOUNT_EN adds the 32-bit icount output.
module hack_fetch_unit #(
  parameter int unsigned          PC_W     = 15,
  parameter int unsigned          INSTR_W  = 16,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               rom_req,
  output logic [PC_W-1:0]    rom_addr,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_taken,
  input  logic [PC_W-1:0]    jump_target
`ifdef FETCH_ICOUNT_EN
  ,
  output logic [31:0]        icount
`endif
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               rom_req_q, rom_req_d;
  logic [PC_W-1:0]    rom_addr_q, rom_addr_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               squash_q, squash_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rom_req_d     = rom_req_q;
    rom_addr_d    = rom_addr_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    squash_d      = squash_q;

    if (jump_taken) pc_d = jump_target;

    case (state_q)
      BOOT: begin
        state_d = REQ;
      end
      REQ: begin
        if (!rom_req_q) begin
          // Idle cycle of REQ: launch the next request (a same-cycle jump wins)
          rom_req_d  = 1'b1;
          rom_addr_d = jump_taken ? jump_target : pc_q;
        end else if (rom_ack) begin
          rom_req_d = 1'b0;
          if (squash_q || jump_taken) begin
            // Stale data: drop it, re-request at the redirected pc after the gap
            squash_d = 1'b0;
          end else begin
            instr_out_d   = rom_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + PC_W'(1);
            state_d       = HOLD;
          end
        end else if (jump_taken) begin
          // Outstanding request must complete unchanged; mark its data stale
          squash_d = 1'b1;
        end
      end
      HOLD: begin
        if (instr_ready || jump_taken) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      rom_req_q     <= 1'b0;
      rom_addr_q    <= RESET_PC;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rom_req_q     <= rom_req_d;
      rom_addr_q    <= rom_addr_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      squash_q      <= squash_d;
    end
  end

  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

`ifdef FETCH_ICOUNT_EN
  logic [31:0] icount_q, icount_d;

  // Count only instructions actually handed to decode
  always_comb begin
    icount_d = icount_q;
    if (instr_valid_q && instr_ready) icount_d = icount_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) icount_q <= '0;
    else        icount_q <= icount_d;
  end

  assign icount = icount_q;
`endif

endmodule
